// File: rtl/pwl_sched.sv
// pwl_sched: round-robin front end that shares one fixed-latency symmetric
// PWL core among NREQ requesters. Requests are folded to |x| plus sign,
// tagged through a pipe aligned with the core latency, corrected for the
// selected symmetry and queued in a credit-protected show-ahead FIFO.
// Optional build macro: PWL_SCHED_STATS_EN adds saturating issue/stall counters.
module pwl_sched #(
   parameter int M     = 4,
   parameter int N     = 8,
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   localparam int W    = M + N,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_x,
   output logic [NREQ-1:0]   req_ready,
   input  logic [1:0]        sym_mode,
   output logic              core_valid,
   output logic [W-1:0]      core_x,
   input  logic [W-1:0]      core_y,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_y,
   input  logic              rsp_ready,
   output logic              busy
`ifdef PWL_SCHED_STATS_EN
   ,
   output logic [15:0]       stat_issue,
   output logic [15:0]       stat_stall
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << N;

   // |x| with the most negative code saturating to the most positive one
   function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] x);
      if (x == {1'b1, {(W-1){1'b0}}}) sat_abs = {1'b0, {(W-1){1'b1}}};
      else if (x[W-1])                sat_abs = -x;
      else                            sat_abs = x;
   endfunction

   // Symmetry correction of the core result, all arithmetic mod 2^W
   function automatic logic [W-1:0] sym_fix(input logic [W-1:0] y,
                                            input logic sgn,
                                            input logic [1:0] mode);
      case (mode)
         2'd0:    sym_fix = sgn ? ({W{1'b0}} - y) : y;
         2'd2:    sym_fix = sgn ? (ONE - y) : y;
         default: sym_fix = y;
      endcase
   endfunction

   logic signed [W-1:0] x_arr [NREQ];
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x_arr[gi] = req_x[gi*W +: W];
   end

   logic [IDW-1:0]      ptr;
   logic [CW-1:0]       credit;
   logic                found_p0;
   logic [IDW-1:0]      gnt_p0;
   logic signed [W-1:0] x_p0;
   logic                issue_p0;
   logic                pop;

   // Stage p0: rotating-priority search starting at ptr
   always_comb begin
      found_p0 = 1'b0;
      gnt_p0   = '0;
      x_p0     = '0;
      for (int k = 0; k < NREQ; k++) begin
         logic [IDW-1:0] idx;
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found_p0 && req_valid[idx]) begin
            found_p0 = 1'b1;
            gnt_p0   = idx;
            x_p0     = x_arr[idx];
         end
      end
   end

   assign issue_p0  = found_p0 && (credit < CW'(DEPTH));
   assign req_ready = issue_p0 ? (NREQ'(1) << gnt_p0) : '0;
   assign busy      = (credit != '0);
   assign pop       = rsp_valid && rsp_ready;

   // Pointer advances past the granted requester; credit tracks in-flight + queued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr    <= '0;
         credit <= '0;
      end else begin
         if (issue_p0)
            ptr <= (gnt_p0 == IDW'(NREQ - 1)) ? '0 : gnt_p0 + 1'b1;
         if (issue_p0 && !pop)      credit <= credit + 1'b1;
         else if (!issue_p0 && pop) credit <= credit - 1'b1;
      end
   end

   // Tag pipe: index 0 is aligned with core_valid, index LAT with core_y
   logic           vld_p [0:LAT];
   logic [IDW-1:0] id_p  [0:LAT];
   logic           sgn_p [0:LAT];

   // Stage p1 issue register and tag shift toward the core result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_x <= '0;
         for (int i = 0; i <= LAT; i++) begin
            vld_p[i] <= 1'b0;
            id_p[i]  <= '0;
            sgn_p[i] <= 1'b0;
         end
      end else begin
         vld_p[0] <= issue_p0;
         id_p[0]  <= gnt_p0;
         sgn_p[0] <= x_p0[W-1];
         if (issue_p0) core_x <= sat_abs(x_p0);
         for (int i = 1; i <= LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            id_p[i]  <= id_p[i-1];
            sgn_p[i] <= sgn_p[i-1];
         end
      end
   end

   assign core_valid = vld_p[0];

   // Response FIFO; the credit check guarantees space for every write
   logic [W-1:0]   mem_y  [DEPTH];
   logic [IDW-1:0] mem_id [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  fcnt;
   logic           wr_en;

   assign wr_en = vld_p[LAT];

   // Storage is data-only and is never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_y[wr_ptr]  <= sym_fix(core_y, sgn_p[LAT], sym_mode);
         mem_id[wr_ptr] <= id_p[LAT];
      end
   end

   // FIFO pointer and occupancy control
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)      fcnt <= fcnt + 1'b1;
         else if (!wr_en && pop) fcnt <= fcnt - 1'b1;
      end
   end

   assign rsp_valid = (fcnt != '0);
   assign rsp_y     = rsp_valid ? mem_y[rd_ptr]  : '0;
   assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;

`ifdef PWL_SCHED_STATS_EN
   // Saturating counters of issues and of credit-starved request cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_issue <= '0;
         stat_stall <= '0;
      end else begin
         if (issue_p0 && stat_issue != 16'hFFFF)
            stat_issue <= stat_issue + 1'b1;
         if (found_p0 && credit == CW'(DEPTH) && stat_stall != 16'hFFFF)
            stat_stall <= stat_stall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pwl_sched.sv
// Directed bench for pwl_sched with a behavioural core f(a)=a>>1, LAT=2.
module tb_pwl_sched;

   localparam int W    = 12;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ-1:0]   req_ready;
   logic [1:0]        sym_mode;
   logic              core_valid;
   logic [W-1:0]      core_x;
   logic [W-1:0]      core_y;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_y;
   logic              rsp_ready;
   logic              busy;
`ifdef PWL_SCHED_STATS_EN
   logic [15:0]       stat_issue;
   logic [15:0]       stat_stall;
`endif

   logic [W-1:0] xs [NREQ];
   logic [W-1:0] c1, c2;
   logic         force_en;
   logic [W-1:0] force_val;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_x[gi*W +: W] = xs[gi];
   end

   // Core model: two register stages of a>>1, optionally overridden
   always_ff @(posedge clk) begin
      c1 <= core_x >> 1;
      c2 <= c1;
   end
   assign core_y = force_en ? force_val : c2;

   pwl_sched #(.M(4), .N(8), .NREQ(NREQ), .LAT(2), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
      .sym_mode(sym_mode),
      .core_valid(core_valid), .core_x(core_x), .core_y(core_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_ready(rsp_ready), .busy(busy)
`ifdef PWL_SCHED_STATS_EN
      , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
   );

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_core_valid"}, core_valid, 0);
      chk({tag, "_core_x"}, core_x, 0);
      chk({tag, "_rsp_y"}, rsp_y, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
   endtask

   // One isolated request on requester idx; rsp_ready held at 1
   task automatic run_one(input string tag, input int idx, input logic [W-1:0] x,
                          input logic [1:0] mode, input logic [W-1:0] exp_cx,
                          input logic [W-1:0] exp_y);
      xs[idx]   = x;
      sym_mode  = mode;
      req_valid = NREQ'(1) << idx;
      smp();
      chk({tag, "_ready"}, req_ready, 32'(NREQ'(1) << idx));
      nxt();
      req_valid = '0;
      smp();
      chk({tag, "_core_valid"}, core_valid, 1);
      chk({tag, "_core_x"}, core_x, exp_cx);
      nxt();
      nxt();
      smp();
      chk({tag, "_early"}, rsp_valid, 0);
      nxt();
      smp();
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_id"}, rsp_id, idx);
      chk({tag, "_rsp_y"}, rsp_y, exp_y);
      nxt();
      smp();
      chk({tag, "_drained"}, rsp_valid, 0);
      chk({tag, "_idle"}, busy, 0);
      nxt();
   endtask

   initial begin
      logic [W-1:0]   exp_y [NREQ];
      logic [3:0]     h;
      int             g;
      int             cr;
      logic           exp_iss;
      logic [IDW-1:0] qid [$];
      logic [IDW-1:0] hid;
      int             seq [4];

      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; sym_mode = 2'd0;
      force_en = 1'b0; force_val = '0;
      for (int i = 0; i < NREQ; i++) xs[i] = '0;

      // Reset state
      repeat (2) nxt();
      smp();
      chk_idle("reset");
      chk("reset_req_ready", req_ready, 0);
      nxt();
      rst_n = 1'b1;
      rsp_ready = 1'b1;

      // Odd mapping: -1.5 -> |x|=1.5 -> 0.75 -> -0.75
      run_one("odd", 0, 12'hE80, 2'd0, 12'h180, 12'hF40);

      // Round robin, all requesters valid, rsp_ready=1, credit modelled
      xs[0] = 12'h010; xs[1] = 12'h123; xs[2] = 12'hD56; xs[3] = 12'h7FE;
      exp_y[0] = 12'h008; exp_y[1] = 12'h091; exp_y[2] = 12'hEAB; exp_y[3] = 12'h3FF;
      sym_mode = 2'd0;
      do_reset();
      h = '0; g = 0;
      for (int k = 0; k < 20; k++) begin
         cr = int'(h[0]) + int'(h[1]) + int'(h[2]) + int'(h[3]);
         exp_iss = (k < 14) && (cr < 4);
         req_valid = (k < 14) ? 4'hF : 4'h0;
         smp();
         chk("rr_ready", req_ready, exp_iss ? 32'(4'b1 << g) : 32'd0);
         chk("rr_rsp_valid", rsp_valid, h[3]);
         if (h[3] && qid.size() > 0) begin
            hid = qid.pop_front();
            chk("rr_rsp_id", rsp_id, hid);
            chk("rr_rsp_y", rsp_y, exp_y[hid]);
         end
         if (exp_iss) begin
            qid.push_back(IDW'(g));
            g = (g + 1) % NREQ;
         end
         h = {h[2:0], exp_iss};
         nxt();
      end
      smp();
      chk("rr_idle", busy, 0);
      nxt();

      // Credit backpressure with rsp_ready low
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         smp();
         chk("bp_accept", req_ready, 32'(4'b1 << k));
         nxt();
      end
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("bp_stall", req_ready, 0);
         chk("bp_busy", busy, 1);
         nxt();
      end
      rsp_ready = 1'b1;
      smp();
      chk("bp_pulse_ready", req_ready, 0);
      chk("bp_pulse_valid", rsp_valid, 1);
      chk("bp_head_id", rsp_id, 0);
      nxt();
      rsp_ready = 1'b0;
      smp();
      chk("bp_next_grant", req_ready, 4'b0001);
      chk("bp_head_after_pop", rsp_id, 1);
      nxt();
      smp();
      chk("bp_full_again", req_ready, 0);
      nxt();
      req_valid = '0;
      rsp_ready = 1'b1;
      seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0;
      for (int k = 0; k < 4; k++) begin
         smp();
         chk("bp_drain_valid", rsp_valid, 1);
         chk("bp_drain_id", rsp_id, seq[k]);
         chk("bp_drain_y", rsp_y, exp_y[seq[k]]);
         nxt();
      end
      smp();
      chk("bp_drain_empty", rsp_valid, 0);
      chk("bp_drain_idle", busy, 0);
      nxt();

      // Saturation of the most negative input, then each mapping on it
      run_one("sat_even", 0, 12'h800, 2'd1, 12'h7FF, 12'h3FF);
      run_one("sat_odd", 1, 12'h800, 2'd0, 12'h7FF, 12'hC01);
      run_one("sat_mode3", 2, 12'h800, 2'd3, 12'h7FF, 12'h3FF);

      // Complement mapping with the core result forced
      force_en = 1'b1; force_val = 12'h0BB;
      run_one("cmp_neg", 3, 12'hF00, 2'd2, 12'h100, 12'h045);
      run_one("cmp_pos", 3, 12'h100, 2'd2, 12'h100, 12'h0BB);
      force_en = 1'b0;

      // Reset with three requests in flight
      sym_mode = 2'd0;
      do_reset();
      req_valid = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("mid_accept", req_ready, 32'(4'b1 << k));
         nxt();
      end
      req_valid = '0;
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      smp();
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_core_valid", core_valid, 0);
      nxt();
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("mid_stale", rsp_valid, 0);
         nxt();
      end
      req_valid = 4'hF;
      smp();
      chk("mid_first_grant", req_ready, 4'b0001);
      nxt();
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
